// File: rtl/poly_acc_modq.sv
// -----------------------------------------------------------------------------
// poly_acc_modq
//   Coefficient-wise modular accumulator for ML-KEM polynomials. Consumes a
//   serial stream of 12-bit coefficients, N per polynomial. It sums n_terms
//   polynomials mod Q into a parallel register, then pulses done_o for one
//   cycle when the sum is complete.
//
// Ports
//   clk_i         in   1      clock, rising edge
//   rst_i         in   1      asynchronous active-high reset
//   start_i       in   1      begin a new accumulation (honoured in IDLE only)
//   num_terms_i   in   3      polynomials to sum, clamped to 1..MAX_TERM
//   coef_valid_i  in   1      coef_i carries a coefficient this cycle
//   coef_i        in   12     coefficient, 0..4095 (need not be reduced)
//   coef_ready_o  out  1      a coefficient is accepted this cycle
//   busy_o        out  1      accumulation in progress
//   done_o        out  1      one-cycle pulse, poly_o is complete
//   poly_o        out  N*12   accumulator, coefficient j at [j*12 +: 12]
//
// Handshake: a beat transfers on a rising edge where coef_valid_i and
// coef_ready_o are both high. If coef_valid_i is high while coef_ready_o is
// low, the beat is dropped. A beat is not held over to a later cycle.
// -----------------------------------------------------------------------------
module poly_acc_modq #(
    parameter int N        = 256,
    parameter int Q        = 3329,
    parameter int MAX_TERM = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      num_terms_i,
    input  logic            coef_valid_i,
    input  logic [11:0]     coef_i,
    output logic            coef_ready_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [N*12-1:0] poly_o
);

    localparam int          IDXW    = $clog2(N);
    localparam logic [11:0] Q12     = 12'(Q);
    localparam logic [12:0] Q13     = 13'(Q);
    localparam logic [2:0]  MAXT    = 3'(MAX_TERM);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [IDXW-1:0]     idx;
    logic [2:0]          term_cnt;
    logic [2:0]          n_terms;
    logic [N-1:0][11:0]  acc;

    logic [11:0] c_red;
    logic [12:0] sum;
    logic [12:0] sum_red;
    logic [11:0] acc_next;
    logic [2:0]  n_terms_clamped;
    logic        beat;
    logic        last_beat;

    // Input is below 2Q, so one conditional subtract fully reduces it.
    // The same holds for the sum of two reduced values.
    always_comb begin
        c_red    = (coef_i >= Q12) ? (coef_i - Q12) : coef_i;
        sum      = {1'b0, acc[idx]} + {1'b0, c_red};
        sum_red  = (sum >= Q13) ? (sum - Q13) : sum;
        acc_next = sum_red[11:0];
    end

    always_comb begin
        if (num_terms_i == 3'd0) begin
            n_terms_clamped = 3'd1;
        end else if (num_terms_i > MAXT) begin
            n_terms_clamped = MAXT;
        end else begin
            n_terms_clamped = num_terms_i;
        end
    end

    assign beat      = coef_valid_i & coef_ready_o;
    assign last_beat = beat && (idx == LAST_IDX) && (term_cnt == n_terms - 3'd1);

    assign poly_o = acc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            idx          <= '0;
            term_cnt     <= '0;
            n_terms      <= 3'd1;
            acc          <= '0;
            coef_ready_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        n_terms      <= n_terms_clamped;
                        acc          <= '0;
                        idx          <= '0;
                        term_cnt     <= '0;
                        state        <= ACC;
                        coef_ready_o <= 1'b1;
                        busy_o       <= 1'b1;
                    end
                end
                ACC: begin
                    // start_i is deliberately not examined here.
                    if (beat) begin
                        acc[idx] <= acc_next;
                        if (idx == LAST_IDX) begin
                            idx      <= '0;
                            term_cnt <= term_cnt + 3'd1;
                        end else begin
                            idx <= idx + IDXW'(1);
                        end
                        if (last_beat) begin
                            state        <= DONE;
                            coef_ready_o <= 1'b0;
                            busy_o       <= 1'b0;
                            done_o       <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state        <= IDLE;
                    coef_ready_o <= 1'b0;
                    busy_o       <= 1'b0;
                    done_o       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_acc_modq.sv
module tb_poly_acc_modq;

    localparam int N = 256;
    localparam int Q = 3329;

    logic            clk_i;
    logic            rst_i;
    logic            start_i;
    logic [2:0]      num_terms_i;
    logic            coef_valid_i;
    logic [11:0]     coef_i;
    logic            coef_ready_o;
    logic            busy_o;
    logic            done_o;
    logic [N*12-1:0] poly_o;

    int total;
    int bad;

    poly_acc_modq dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .num_terms_i  (num_terms_i),
        .coef_valid_i (coef_valid_i),
        .coef_i       (coef_i),
        .coef_ready_o (coef_ready_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .poly_o       (poly_o)
    );

    // ---------------- clock ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic int gen(input int pat, input int j);
        case (pat)
            0:       return j;
            1:       return 3000;
            2:       return 4095;
            3:       return 3328;
            default: return int'($urandom_range(0, 4095));
        endcase
    endfunction

    function automatic int poly_at(input int j);
        return int'(poly_o[j*12 +: 12]);
    endfunction

    // ---------------- reset check ----------------
    task automatic test_reset();
        rst_i = 1'b1; start_i = 0; num_terms_i = 0; coef_valid_i = 0; coef_i = 0;
        #2;
        total++;
        if ({coef_ready_o, busy_o, done_o} !== 3'b000) begin
            bad++;
            $display("FAIL reset_outputs: got ready/busy/done=%b want 000", {coef_ready_o, busy_o, done_o});
        end
        total++;
        if (poly_o !== '0) begin
            bad++;
            $display("FAIL reset_poly: poly_o not zero");
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    // ---------------- one full accumulation ----------------
    // bub: 0 gapless, 1 valid toggles 1-0-1, 2 random valid
    task automatic run_job(input string name, input int nt_in, input int pat,
                           input int bub, input int start_mid, input int spot);
        int eff, ntot, beat, cycles, v, early, ready_miss, errs;
        int coefs[1024];
        int expv[N];
        eff  = (nt_in == 0) ? 1 : (nt_in > 4 ? 4 : nt_in);
        ntot = eff * N;
        for (int j = 0; j < N; j++) expv[j] = 0;
        for (int b = 0; b < ntot; b++) begin
            coefs[b] = gen(pat, b % N);
            expv[b % N] = (expv[b % N] + coefs[b] % Q) % Q;
        end

        // start together with a valid coefficient: the coefficient must be dropped
        start_i = 1'b1; num_terms_i = 3'(nt_in);
        coef_valid_i = 1'b1; coef_i = 12'(4000);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        total++;
        if ({coef_ready_o, busy_o} !== 2'b11) begin
            bad++;
            $display("FAIL %s_first_ready: got ready/busy=%b want 11", name, {coef_ready_o, busy_o});
        end
        total++;
        if (poly_o !== '0) begin
            bad++;
            $display("FAIL %s_clear: poly_o not zero after start", name);
        end

        beat = 0; cycles = 0; early = 0; ready_miss = 0;
        while (beat < ntot && cycles < 5000) begin
            case (bub)
                0:       v = 1;
                1:       v = (cycles % 2 == 0) ? 1 : 0;
                default: v = int'($urandom_range(0, 1));
            endcase
            start_i = (start_mid != 0 && cycles == 300);
            num_terms_i = start_i ? 3'd1 : 3'(nt_in);
            coef_valid_i = (v != 0);
            coef_i = 12'(coefs[beat]);
            if (v != 0 && coef_ready_o !== 1'b1) ready_miss = 1;
            @(posedge clk_i); #1;
            if (v != 0) beat++;
            cycles++;
            if (beat < ntot && done_o !== 1'b0) early = 1;
        end
        start_i = 1'b0;
        coef_valid_i = 1'b0;

        total++;
        if (beat < ntot) begin
            bad++;
            $display("FAIL %s_timeout: accepted %0d beats want %0d", name, beat, ntot);
        end
        total++;
        if (early != 0 || ready_miss != 0) begin
            bad++;
            $display("FAIL %s_stream: early_done=%0d ready_drop=%0d want 0 0", name, early, ready_miss);
        end
        total++;
        if ({done_o, busy_o, coef_ready_o} !== 3'b100) begin
            bad++;
            $display("FAIL %s_done: got done/busy/ready=%b want 100", name, {done_o, busy_o, coef_ready_o});
        end
        if (bub == 0) begin
            total++;
            if (cycles != ntot) begin
                bad++;
                $display("FAIL %s_latency: done after %0d cycles want %0d", name, cycles, ntot);
            end
        end
        errs = 0;
        for (int j = 0; j < N; j++) begin
            if (poly_at(j) !== expv[j]) begin
                errs++;
                if (errs <= 8) $display("info %s coef %0d: got %0d want %0d", name, j, poly_at(j), expv[j]);
            end
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s_sum: %0d coefficients wrong, want 0", name, errs);
        end
        if (spot >= 0) begin
            total++;
            if (poly_at(200) !== spot) begin
                bad++;
                $display("FAIL %s_spot: poly[200]=%0d want %0d", name, poly_at(200), spot);
            end
        end

        @(posedge clk_i); #1;
        total++;
        if ({done_o, busy_o, coef_ready_o} !== 3'b000) begin
            bad++;
            $display("FAIL %s_pulse: got done/busy/ready=%b want 000", name, {done_o, busy_o, coef_ready_o});
        end
        errs = 0;
        for (int j = 0; j < N; j++) if (poly_at(j) !== expv[j]) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s_hold: %0d coefficients changed after done, want 0", name, errs);
        end
    endtask

    // ---------------- reset during term 2 ----------------
    task automatic test_reset_mid();
        int beat;
        start_i = 1'b1; num_terms_i = 3'd4;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        beat = 0;
        while (beat < N + 100) begin
            coef_valid_i = 1'b1;
            coef_i = 12'($urandom_range(1, 3000));
            @(posedge clk_i); #1;
            beat++;
        end
        #2 rst_i = 1'b1;
        #1;
        total++;
        if ({coef_ready_o, busy_o, done_o} !== 3'b000 || poly_o !== '0) begin
            bad++;
            $display("FAIL reset_mid: got ready/busy/done=%b poly_zero=%0d want 000 1",
                     {coef_ready_o, busy_o, done_o}, (poly_o == '0));
        end
        coef_valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            coef_valid_i = 1'b1;
            @(posedge clk_i); #1;
        end
        coef_valid_i = 1'b0;
        total++;
        if ({coef_ready_o, busy_o, done_o} !== 3'b000 || poly_o !== '0) begin
            bad++;
            $display("FAIL reset_idle: got ready/busy/done=%b want 000 and zero poly",
                     {coef_ready_o, busy_o, done_o});
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        run_job("single",    1, 0, 0, 0, 200);
        run_job("modwrap",   2, 1, 0, 0, 2671);
        run_job("unreduced", 1, 2, 0, 0, 766);
        run_job("three",     3, 3, 0, 0, 3326);
        run_job("bubbles",   4, 4, 1, 0, -1);
        run_job("rand_gaps", 2, 4, 2, 0, -1);
        run_job("zero_term", 0, 4, 0, 0, -1);
        run_job("clamp7",    7, 4, 0, 0, -1);
        run_job("start_mid", 2, 4, 0, 1, -1);
        test_reset_mid();
        run_job("after_rst", 2, 4, 0, 0, -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
